// File: rtl/fog_cfg_pkg.sv
// Shared types and register map for the FOG closed-loop channel configuration sequencer.
package fog_cfg_pkg;

    localparam logic [3:0] ADDR_FREQ       = 4'd0;
    localparam logic [3:0] ADDR_AMP_H      = 4'd1;
    localparam logic [3:0] ADDR_AMP_L      = 4'd2;
    localparam logic [3:0] ADDR_POLARITY   = 4'd3;
    localparam logic [3:0] ADDR_WAIT       = 4'd4;
    localparam logic [3:0] ADDR_ERR_OFS    = 4'd5;
    localparam logic [3:0] ADDR_AVG_SEL    = 4'd6;
    localparam logic [3:0] ADDR_CONST_STEP = 4'd7;
    localparam logic [3:0] ADDR_FB_ON      = 4'd8;
    localparam logic [3:0] ADDR_GAIN_STEP  = 4'd9;
    localparam logic [3:0] ADDR_GAIN_RAMP  = 4'd10;
    localparam logic [3:0] ADDR_COMMIT     = 4'd11;
    localparam logic [3:0] ADDR_CLR_TO     = 4'd12;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2
    } fog_state_e;

    typedef struct packed {
        logic [31:0] freq_cnt;
        logic [31:0] amp_H;
        logic [31:0] amp_L;
        logic [31:0] polarity;
        logic [31:0] wait_cnt;
        logic [31:0] err_offset;
        logic [31:0] avg_sel;
        logic [31:0] const_step;
        logic [31:0] fb_ON;
        logic [31:0] gainSel_step;
        logic [31:0] gainSel_ramp;
    } fog_cfg_t;

    function automatic fog_cfg_t cfg_default(input logic [31:0] freq_cnt);
        fog_cfg_t c;
        c = '0;
        c.freq_cnt = freq_cnt;
        return c;
    endfunction

endpackage

// File: rtl/fog_cfg_shadow_bank.sv
// Host-facing shadow registers and the active bank they are copied into on a commit.
module fog_cfg_shadow_bank
    import fog_cfg_pkg::*;
#(
    parameter logic [31:0] DEF_FREQ_CNT = 32'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    output fog_cfg_t    active,
    output logic        freq_change,
    output logic [31:0] shadow_fb_on
);

    fog_cfg_t shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= cfg_default(DEF_FREQ_CNT);
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_FREQ:       shadow.freq_cnt     <= wr_data;
                ADDR_AMP_H:      shadow.amp_H        <= wr_data;
                ADDR_AMP_L:      shadow.amp_L        <= wr_data;
                ADDR_POLARITY:   shadow.polarity     <= wr_data;
                ADDR_WAIT:       shadow.wait_cnt     <= wr_data;
                ADDR_ERR_OFS:    shadow.err_offset   <= wr_data;
                ADDR_AVG_SEL:    shadow.avg_sel      <= wr_data;
                ADDR_CONST_STEP: shadow.const_step   <= wr_data;
                ADDR_FB_ON:      shadow.fb_ON        <= wr_data;
                ADDR_GAIN_STEP:  shadow.gainSel_step <= wr_data;
                ADDR_GAIN_RAMP:  shadow.gainSel_ramp <= wr_data;
                default: ;
            endcase
        end
    end

    // Writes are blocked while a commit is pending, so commit and write never share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= cfg_default(DEF_FREQ_CNT);
        end else if (commit) begin
            active <= shadow;
        end
    end

    assign freq_change  = (shadow.freq_cnt != active.freq_cnt);
    assign shadow_fb_on = shadow.fb_ON;

endmodule

// File: rtl/fog_cfg_sequencer.sv
// FOG channel configuration sequencer: trigger-aligned commits and settle/run/hold loop control.
module fog_cfg_sequencer
    import fog_cfg_pkg::*;
#(
    parameter int SETTLE_TRIGS = 64,
    parameter int TRIG_TIMEOUT = 1000000,
    parameter int DEF_FREQ_CNT = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [3:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic        i_stepTrig,
    output logic [31:0] o_var_freq_cnt,
    output logic [31:0] o_var_amp_H,
    output logic [31:0] o_var_amp_L,
    output logic [31:0] o_var_wait_cnt,
    output logic [31:0] o_var_err_offset,
    output logic [31:0] o_var_avg_sel,
    output logic [31:0] o_var_const_step,
    output logic [31:0] o_var_gainSel_step,
    output logic [31:0] o_var_gainSel_ramp,
    output logic        o_var_polarity,
    output logic [31:0] o_var_fb_ON,
    output logic [1:0]  o_state,
    output logic        o_commit_pend,
    output logic        o_timeout
);

    localparam int SW = $clog2(SETTLE_TRIGS + 1);
    localparam int TW = $clog2(TRIG_TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TRIGS - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TRIG_TIMEOUT - 1);

    fog_state_e     state;
    logic [SW-1:0]  settle_cnt;
    logic [TW-1:0]  timeout_cnt;
    logic           commit_pend;
    logic           wr_accept;
    logic           commit_fire;
    logic           freq_change;
    logic [31:0]    shadow_fb_on;
    fog_cfg_t       active;
    logic           unused_polarity_bits;

    assign o_wr_ready  = !i_rst && !commit_pend;
    assign wr_accept   = i_wr_valid && o_wr_ready;
    assign commit_fire = commit_pend && (i_stepTrig || timeout_cnt == TO_LAST);

    fog_cfg_shadow_bank #(
        .DEF_FREQ_CNT (32'(DEF_FREQ_CNT))
    ) u_bank (
        .clk          (i_clk),
        .rst          (i_rst),
        .wr_en        (wr_accept),
        .wr_addr      (i_wr_addr),
        .wr_data      (i_wr_data),
        .commit       (commit_fire),
        .active       (active),
        .freq_change  (freq_change),
        .shadow_fb_on (shadow_fb_on)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            commit_pend <= 1'b0;
            timeout_cnt <= '0;
            o_timeout   <= 1'b0;
        end else if (commit_fire) begin
            commit_pend <= 1'b0;
            timeout_cnt <= '0;
            if (!i_stepTrig) begin
                o_timeout <= 1'b1;
            end
        end else begin
            if (commit_pend && timeout_cnt != TO_LAST) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
            if (wr_accept && i_wr_addr == ADDR_COMMIT) begin
                commit_pend <= 1'b1;
            end
            if (wr_accept && i_wr_addr == ADDR_CLR_TO) begin
                o_timeout <= 1'b0;
            end
        end
    end

    // Commit decisions take priority over settle counting; a HOLD commit keeps fb off regardless of freq.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            o_var_fb_ON <= '0;
        end else if (commit_fire && freq_change && state != ST_HOLD) begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            o_var_fb_ON <= '0;
        end else if (commit_fire && state == ST_HOLD) begin
            if (shadow_fb_on != '0) begin
                state      <= ST_SETTLE;
                settle_cnt <= '0;
            end
            o_var_fb_ON <= '0;
        end else if (commit_fire && state == ST_RUN) begin
            if (shadow_fb_on == '0) begin
                state <= ST_HOLD;
            end
            o_var_fb_ON <= shadow_fb_on;
        end else if (state == ST_SETTLE) begin
            o_var_fb_ON <= '0;
            if (i_stepTrig) begin
                if (settle_cnt >= SETTLE_LAST) begin
                    state       <= ST_RUN;
                    settle_cnt  <= '0;
                    o_var_fb_ON <= commit_fire ? shadow_fb_on : active.fb_ON;
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
        end else if (state == ST_RUN) begin
            o_var_fb_ON <= active.fb_ON;
        end else begin
            o_var_fb_ON <= '0;
            if (state != ST_HOLD) begin
                state <= ST_SETTLE;
            end
        end
    end

    assign o_state            = state;
    assign o_commit_pend      = commit_pend;
    assign o_var_freq_cnt     = active.freq_cnt;
    assign o_var_amp_H        = active.amp_H;
    assign o_var_amp_L        = active.amp_L;
    assign o_var_wait_cnt     = active.wait_cnt;
    assign o_var_err_offset   = active.err_offset;
    assign o_var_avg_sel      = active.avg_sel;
    assign o_var_const_step   = active.const_step;
    assign o_var_gainSel_step = active.gainSel_step;
    assign o_var_gainSel_ramp = active.gainSel_ramp;
    assign o_var_polarity     = active.polarity[0];
    assign unused_polarity_bits = ^active.polarity[31:1];

endmodule

// File: doc/fog_cfg_sequencer.md
Name: fog_cfg_sequencer

Overview:
- Run-time configuration controller for one FOG closed-loop channel: modulation generator, error-signal generator, feedback step generator and phase ramp generator.
- Host writes land in a shadow register bank. A commit copies the shadow bank into the active bank only at a modulation step trigger, so the datapath never sees a mid-cycle parameter change.
- Sequences loop start-up and re-lock: feedback is held off for a settling interval after reset or after a frequency change, then enabled.

Parameters:
- SETTLE_TRIGS, 64: stepTrig pulses with feedback forced off before the loop may close.
- TRIG_TIMEOUT, 1000000: clock cycles a pending commit waits for stepTrig before a forced commit.
- DEF_FREQ_CNT, 100: reset value of the freq_cnt register. The other registers reset to 0.

Ports:
- i_clk, in, 1: CLOCK_DAC domain clock.
- i_rst, in, 1: async active-high reset.
- i_wr_valid, in, 1: host write request.
- o_wr_ready, out, 1: write accepted when i_wr_valid && o_wr_ready.
- i_wr_addr, in, 4: register index.
- i_wr_data, in, 32: write data.
- i_stepTrig, in, 1: one-cycle pulse from the modulation generator.
- o_var_freq_cnt / o_var_amp_H / o_var_amp_L / o_var_wait_cnt / o_var_err_offset / o_var_avg_sel / o_var_const_step / o_var_gainSel_step / o_var_gainSel_ramp, out, 32 each: active bank.
- o_var_polarity, out, 1: active polarity (bit 0 of reg 3).
- o_var_fb_ON, out, 32: gated feedback enable.
- o_state, out, 2: FSM state.
- o_commit_pend, out, 1: commit waiting for a trigger.
- o_timeout, out, 1: sticky forced-commit flag.

Behaviour:
- Register map: 0 freq_cnt, 1 amp_H, 2 amp_L, 3 polarity, 4 wait_cnt, 5 err_offset, 6 avg_sel, 7 const_step, 8 fb_ON, 9 gainSel_step, 10 gainSel_ramp, 11 COMMIT (data ignored; sets commit_pend), 12 CLR_TIMEOUT (clears o_timeout), 13-15 write-accepted, ignored.
- Reset (async): shadow and active banks take their defaults. commit_pend=0, o_timeout=0, state=SETTLE, settle counter=0, timeout counter=0, o_var_fb_ON=0, o_wr_ready=0 during reset.
- Handshake:
  - o_wr_ready = !commit_pend.
  - An accepted write updates the shadow bank on the next edge.
  - The active bank never changes on a write.
- Commit:
  - Fires at the first cycle with commit_pend && (i_stepTrig || timeout counter == TRIG_TIMEOUT-1).
  - The active bank equals the shadow bank one cycle after that edge. Outputs are registered.
  - commit_pend clears on the same edge.
  - A timeout-driven commit sets o_timeout.
  - The timeout counter counts only while commit_pend and clears on commit.
  - COMMIT while already pending is impossible because ready is low.
- FSM states: SETTLE=0, RUN=1, HOLD=2.
  - SETTLE: o_var_fb_ON=0. The settle counter increments on each i_stepTrig. At SETTLE_TRIGS-1 with a trigger, go to RUN and clear the counter.
  - RUN: o_var_fb_ON = active fb_ON.
    - A commit that changes freq_cnt (shadow != active) goes to SETTLE, counter=0, and fb is forced off the same cycle the new freq_cnt appears.
    - A commit that writes fb_ON=0 goes to HOLD.
  - HOLD: o_var_fb_ON=0. A commit with fb_ON != 0 goes to SETTLE.
  - In SETTLE, a commit with a freq_cnt change restarts the counter at 0.
- Simultaneous events:
  - When a commit and a settle-terminal trigger land on the same edge, the commit decision wins: with a freq change, stay in SETTLE and restart.
  - A trigger while the shadow bank equals the active bank still consumes the commit.
- Width rules:
  - Counters: settle counter $clog2(SETTLE_TRIGS+1) bits, timeout counter $clog2(TRIG_TIMEOUT) bits, both saturating-safe.
  - No arithmetic on register data.

Decomposition:
- Package fog_cfg_pkg:
  - Address localparams ADDR_FREQ..ADDR_CLR_TO.
  - typedef enum logic [1:0] {ST_SETTLE, ST_RUN, ST_HOLD}.
  - typedef struct packed fog_cfg_t holding the 11 fields.
- Sub-module fog_cfg_shadow_bank: shadow regs, address decode, commit copy, change-detect for freq_cnt.
- Top level: FSM, settle and timeout counters.

Test Plan:
- Reset, stepTrig every 300 cycles, reg 8 = 1 and COMMIT -> o_var_fb_ON stays 0 until 64 triggers elapse, then 1; o_state 0->1.
- In RUN, write amp_H=0x1000 then COMMIT, trigger 137 cycles later -> o_var_amp_H still old for 137 cycles, 0x1000 one cycle after trigger; o_wr_ready low throughout.
- In RUN, write freq_cnt=200 and COMMIT -> at commit, o_var_fb_ON=0 and state=SETTLE; back to RUN after 64 more triggers.
- COMMIT with i_stepTrig tied 0, TRIG_TIMEOUT=50 in bench -> commit at cycle 50, o_timeout=1; write reg 12 -> o_timeout=0.
- Write fb_ON=0 and COMMIT -> HOLD, fb 0; write fb_ON=1 and COMMIT -> SETTLE, then RUN after 64 triggers.
- Assert i_rst asynchronously mid-commit (pending) -> all outputs at defaults immediately, commit_pend=0, state=SETTLE.
